seg_scan_driver: RTL and testbench

//  Downstream of the display-select mux: takes its 32-bit selected word and drives
//  an 8-digit multiplexed common-anode seven-segment display as 8 hex nibbles.

---
 rtl/seg_pkg.sv | 38 +++
 rtl/hex_to_seg7.sv | 20 ++
 rtl/seg_scan_driver.sv | 134 +++++++++++++
 tb/tb_seg_scan_driver.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
// Shared constants and helpers for the seven-segment scan driver.
//   NUM_DIGITS  : number of multiplexed digits on the display
//   IDX_W       : width of a digit index
//   SEG_OFF     : active-low segment pattern with every segment dark
//   HEX7_TABLE  : active-low {g,f,e,d,c,b,a} codes for hex digits 0..F
//   highest_nonzero() : index of the most significant nonzero nibble of a
//                       32-bit word (0 when the whole word is zero)
// ---------------------------------------------------------------------------
package seg_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int IDX_W      = $clog2(NUM_DIGITS);

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [6:0] HEX7_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Scan from the low nibble upward so the last nonzero nibble found wins;
    // an all-zero word reports digit 0, which is never blanked.
    function automatic logic [IDX_W-1:0] highest_nonzero(input logic [31:0] word);
        logic [IDX_W-1:0] hi;
        hi = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (word[4*i +: 4] != 4'h0) begin
                hi = IDX_W'(i);
            end
        end
        return hi;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// ---------------------------------------------------------------------------
// hex_to_seg7
// Combinational hex nibble to active-low seven-segment decoder.
//   nibble : in  4  hex value 0..F
//   seg    : out 7  segments {g,f,e,d,c,b,a}, active-low
// ---------------------------------------------------------------------------
module hex_to_seg7
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Straight table lookup; the table lives in the package so the codes
    // are defined in exactly one place.
    always_comb begin
        seg = HEX7_TABLE[nibble];
    end

endmodule

// File: rtl/seg_scan_driver.sv
// ---------------------------------------------------------------------------
// seg_scan_driver
// Drives an 8-digit multiplexed common-anode seven-segment display from a
// 32-bit word shown as 8 hex nibbles (digit 0 rightmost). Each digit is
// selected for SCAN_DIV clocks; the first BLANK_CYC clocks of each dwell
// keep all anodes off to suppress ghosting. The word and decimal points
// are snapshotted once per frame so a digit never tears mid-scan.
//
// Parameters:
//   SCAN_DIV  : clocks per digit dwell (>= 2)
//   BLANK_CYC : dark clocks at the start of each dwell (0..SCAN_DIV-1)
//
// Ports:
//   clk     : in  1   system clock, rising edge
//   reset   : in  1   asynchronous active-high reset
//   data_in : in  32  word to display, sampled only at frame end
//   dp_in   : in  8   decimal point request per digit, 1 = lit
//   an      : out 8   anode enables, active-low, an[i] = digit i
//   seg     : out 7   segments {g,f,e,d,c,b,a}, active-low
//   dp      : out 1   decimal point, active-low
//
// Build option:
//   SEG_LZ_BLANK_EN : when defined, digits above the highest nonzero nibble
//                     of the snapshot stay dark (digit 0 always shown).
// ---------------------------------------------------------------------------
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int SCAN_DIV  = 1000,
    parameter int BLANK_CYC = 2
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_in,
    input  logic [7:0]  dp_in,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int               CNT_W    = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic [31:0]      snap;
    logic [7:0]       dp_snap;
    logic             cnt_wrap;
    logic             frame_end;
    logic             blank_now;
    logic             digit_blank;
    logic [3:0]       nibble;
    logic [6:0]       seg_code;

    assign cnt_wrap  = (cnt == CNT_LAST);
    assign frame_end = cnt_wrap && (idx == IDX_LAST);

    // The count is widened to a signed int so the comparison stays
    // well-formed even when BLANK_CYC is zero.
    assign blank_now = int'(cnt) < BLANK_CYC;

    // Prescaler and digit index: cnt paces the dwell, idx advances on
    // every wrap and rolls naturally from 7 back to 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt_wrap) begin
            cnt <= '0;
            idx <= idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Frame snapshot: captured on the last clock of digit 7 so the new word
    // appears exactly at the start of the next frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap    <= '0;
            dp_snap <= '0;
        end else if (frame_end) begin
            snap    <= data_in;
            dp_snap <= dp_in;
        end
    end

`ifdef SEG_LZ_BLANK_EN
    logic [IDX_W-1:0] lz_hi;

    // The highest lit digit is computed once per frame alongside the
    // snapshot, keeping the priority scan off the per-cycle output path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lz_hi <= '0;
        end else if (frame_end) begin
            lz_hi <= highest_nonzero(data_in);
        end
    end

    assign digit_blank = (idx > lz_hi);
`else
    assign digit_blank = 1'b0;
`endif

    assign nibble = snap[{idx, 2'b00} +: 4];

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (nibble),
        .seg    (seg_code)
    );

    // Output registers: reflect the current cnt/idx one clock later. A
    // blanked digit (ghost gap or leading zero) goes fully dark, including
    // its decimal point.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an  <= 8'hFF;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else if (blank_now || digit_blank) begin
            an  <= 8'hFF;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else begin
            an  <= ~(8'b1 << idx);
            seg <= seg_code;
            dp  <= ~dp_snap[idx];
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_driver
// Self-checking bench for seg_scan_driver with SCAN_DIV=4. Two instances
// share all inputs: dut uses BLANK_CYC=1, dut_nb uses BLANK_CYC=0.
// Expected outputs come from a frame-time model: elapsed clocks since reset
// give the digit and dwell phase, and each frame shows the word present at
// the end of the previous frame.
// ---------------------------------------------------------------------------
module tb_seg_scan_driver;

    localparam int SD     = 4;
    localparam int FRAME  = 8 * SD;

    localparam logic [6:0] HEX_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct {
        logic [15:0] out_b1;
        logic [15:0] out_b0;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] data_in;
    logic [7:0]  dp_in;
    logic [7:0]  an,    an_nb;
    logic [6:0]  seg,   seg_nb;
    logic        dp,    dp_nb;

    exp_t        sb_q[$];
    int          checks;
    int          errors;

    int          m_t;
    logic [31:0] m_data;
    logic [7:0]  m_dp;

    seg_scan_driver #(.SCAN_DIV(SD), .BLANK_CYC(1)) dut (
        .clk     (clk),
        .reset   (reset),
        .data_in (data_in),
        .dp_in   (dp_in),
        .an      (an),
        .seg     (seg),
        .dp      (dp)
    );

    seg_scan_driver #(.SCAN_DIV(SD), .BLANK_CYC(0)) dut_nb (
        .clk     (clk),
        .reset   (reset),
        .data_in (data_in),
        .dp_in   (dp_in),
        .an      (an_nb),
        .seg     (seg_nb),
        .dp      (dp_nb)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the stimulus sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL timeout: stimulus did not complete");
        $fatal(1, "[TB] timeout");
    end

    // Expected {an, seg, dp} for the display state t clocks after reset.
    function automatic logic [15:0] model_out(input int t, input int blank,
                                              input logic [31:0] d, input logic [7:0] p);
        int         phase;
        int         dig;
        int         hi;
        logic [7:0] an_e;
        logic [3:0] nib;
        phase = t % SD;
        dig   = (t / SD) % 8;
        hi    = 0;
        for (int i = 0; i < 8; i++) begin
            if (((d >> (4 * i)) & 32'hF) != 0) hi = i;
        end
        if (phase < blank) return {8'hFF, 7'h7F, 1'b1};
`ifdef SEG_LZ_BLANK_EN
        if (dig > hi) return {8'hFF, 7'h7F, 1'b1};
`endif
        an_e      = 8'hFF;
        an_e[dig] = 1'b0;
        nib       = 4'((d >> (4 * dig)) & 32'hF);
        return {an_e, HEX_TAB[nib], ~p[dig]};
    endfunction

    task automatic applyStimulus(input logic [31:0] d, input logic [7:0] p);
        data_in = d;
        dp_in   = p;
    endtask

    // Push the expectation for the state the DUT is presenting right now.
    task automatic pushExpected();
        exp_t e;
        if (reset) begin
            e.out_b1 = {8'hFF, 7'h7F, 1'b1};
            e.out_b0 = {8'hFF, 7'h7F, 1'b1};
        end else begin
            e.out_b1 = model_out(m_t, 1, m_data, m_dp);
            e.out_b0 = model_out(m_t, 0, m_data, m_dp);
        end
        sb_q.push_back(e);
    endtask

    task automatic checkOutput(input string tag);
        exp_t        e;
        logic [15:0] obs_b1;
        logic [15:0] obs_b0;
        checks++;
        assert (sb_q.size() > 0) else begin
            errors++;
            $error("[TB] FAIL %s scoreboard empty: observed size %0d expected >0", tag, sb_q.size());
        end
        if (sb_q.size() > 0) begin
            e      = sb_q.pop_front();
            obs_b1 = {an, seg, dp};
            obs_b0 = {an_nb, seg_nb, dp_nb};
            checks++;
            assert (obs_b1 === e.out_b1) else begin
                errors++;
                $error("[TB] FAIL %s blank1 t=%0d {an,seg,dp}: observed %h expected %h",
                       tag, m_t, obs_b1, e.out_b1);
            end
            checks++;
            assert (obs_b0 === e.out_b0) else begin
                errors++;
                $error("[TB] FAIL %s blank0 t=%0d {an,seg,dp}: observed %h expected %h",
                       tag, m_t, obs_b0, e.out_b0);
            end
        end
    endtask

    // Advance n clocks: at each edge record the expectation for the state
    // being registered, advance the model, then check 1 unit later.
    task automatic runCycles(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            pushExpected();
            if (reset) begin
                m_t    = 0;
                m_data = '0;
                m_dp   = '0;
            end else begin
                if ((m_t % FRAME) == FRAME - 1) begin
                    m_data = data_in;
                    m_dp   = dp_in;
                end
                m_t++;
            end
            #1;
            checkOutput(tag);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_t    = 0;
        m_data = '0;
        m_dp   = '0;
        reset  = 1'b1;
        applyStimulus(32'h0, 8'h00);

        // Reset held for three clocks: everything dark.
        runCycles(3, "reset_hold");
        @(negedge clk);
        reset = 1'b0;

        // First frame shows zeros; the steady word is loaded for frame 2.
        applyStimulus(32'h12345678, 8'h01);
        runCycles(FRAME, "frame1_zeros");
        runCycles(FRAME, "frame2_word");

        // Change the word halfway through frame 3: old nibbles finish the
        // frame, the new word appears from frame 4.
        runCycles(FRAME / 2, "frame3_early");
        applyStimulus(32'h9ABCDEF0, 8'h80);
        runCycles(FRAME / 2, "frame3_late");
        runCycles(FRAME, "frame4_new");

        // Advance into frame 5 until the DUT state is idx=5, cnt=2, then
        // hit reset between clock edges.
        while ((m_t % FRAME) != 5 * SD + 2) runCycles(1, "pre_reset");
        #1;
        reset = 1'b1;
        #1;
        pushExpected();
        checkOutput("async_reset");
        runCycles(2, "reset_mid");
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(32'h000000A0, 8'hFF);
        runCycles(FRAME, "restart_frame");
        runCycles(FRAME, "lz_a0");

        // All-zero word: with leading-zero blanking only digit 0 stays lit.
        applyStimulus(32'h00000000, 8'h03);
        runCycles(FRAME, "lz_pre_zero");
        runCycles(FRAME, "lz_zero");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
